// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU MEM stage, debug/DMA) in front of the single-port data RAM.
// Optional address checking is compiled in with `define DMEM_ARB_ADDR_CHECK_EN.
module dmem_arbiter #(
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned MAX_STARVE = 3,
   parameter logic [19:0] BASE_HI    = 20'h10010
) (
   input  logic        clockCPU,
   input  logic        reset,

   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,

   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,

   output logic [9:0]  mem_address,
   output logic [31:0] mem_data,
   output logic        mem_wren,
   input  logic [31:0] mem_q,

   output logic        busy,
   output logic        err
);

   localparam int unsigned SW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
   localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

   state_e         state_q;
   logic [SW-1:0]  starve_q;
   logic [2:0]     wait_cnt_q;
   logic           owner_q;
   logic           we_q;
   logic           bad_q;
   logic           cpu_gnt_q;
   logic           dbg_gnt_q;
   logic           cpu_rvalid_q;
   logic           dbg_rvalid_q;
   logic [31:0]    cpu_rdata_q;
   logic [31:0]    dbg_rdata_q;
   logic [9:0]     mem_address_q;
   logic [31:0]    mem_data_q;
   logic           mem_wren_q;
   logic           err_q;

   logic           dbg_wins;
   logic           win_we;
   logic [31:0]    win_addr;
   logic [31:0]    win_wdata;
   logic           win_bad;
   logic [31:0]    rdata_in;

   // Debug wins when alone, or when the CPU has used up its starvation allowance.
   always_comb begin
      dbg_wins  = dbg_req & (~cpu_req | (starve_q == STARVE_MAX));
      win_we    = dbg_wins ? dbg_we    : cpu_we;
      win_addr  = dbg_wins ? dbg_addr  : cpu_addr;
      win_wdata = dbg_wins ? dbg_wdata : cpu_wdata;
   end

`ifdef DMEM_ARB_ADDR_CHECK_EN
   assign win_bad = (win_addr[1:0] != 2'b00) || (win_addr[31:12] != BASE_HI);
`else
   logic unused_addr_bits;
   assign win_bad          = 1'b0;
   assign unused_addr_bits = ^{win_addr[31:12], win_addr[1:0], BASE_HI};
`endif

   assign rdata_in = bad_q ? 32'hDEAD_BEEF : mem_q;

   always_ff @(posedge clockCPU or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         starve_q      <= '0;
         wait_cnt_q    <= '0;
         owner_q       <= 1'b0;
         we_q          <= 1'b0;
         bad_q         <= 1'b0;
         cpu_gnt_q     <= 1'b0;
         dbg_gnt_q     <= 1'b0;
         cpu_rvalid_q  <= 1'b0;
         dbg_rvalid_q  <= 1'b0;
         cpu_rdata_q   <= '0;
         dbg_rdata_q   <= '0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         mem_wren_q    <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         cpu_gnt_q    <= 1'b0;
         dbg_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         mem_wren_q   <= 1'b0;
         err_q        <= 1'b0;
         if (!dbg_req) begin
            starve_q <= '0;
         end

         unique case (state_q)
            StIdle: begin
               if (cpu_req || dbg_req) begin
                  state_q       <= StAccess;
                  owner_q       <= dbg_wins;
                  we_q          <= win_we;
                  bad_q         <= win_bad;
                  mem_address_q <= win_addr[11:2];
                  mem_data_q    <= win_wdata;
                  mem_wren_q    <= win_we & ~win_bad;
                  cpu_gnt_q     <= ~dbg_wins;
                  dbg_gnt_q     <= dbg_wins;
                  err_q         <= win_bad;
                  if (dbg_wins) begin
                     starve_q <= '0;
                  end else if (dbg_req && (starve_q != STARVE_MAX)) begin
                     starve_q <= starve_q + SW'(1);
                  end
               end
            end
            StAccess: begin
               state_q    <= we_q ? StIdle : StWait;
               wait_cnt_q <= WAIT_INIT;
            end
            StWait: begin
               if (wait_cnt_q == 3'd0) begin
                  state_q <= StResp;
                  if (owner_q) begin
                     dbg_rdata_q  <= rdata_in;
                     dbg_rvalid_q <= 1'b1;
                  end else begin
                     cpu_rdata_q  <= rdata_in;
                     cpu_rvalid_q <= 1'b1;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q - 3'd1;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign cpu_gnt     = cpu_gnt_q;
   assign dbg_gnt     = dbg_gnt_q;
   assign cpu_rvalid  = cpu_rvalid_q;
   assign dbg_rvalid  = dbg_rvalid_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign dbg_rdata   = dbg_rdata_q;
   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;
   assign mem_wren    = mem_wren_q;
   assign err         = err_q;
   assign busy        = (state_q != StIdle);

   // Held low during reset so every output reads 0 while reset is asserted.
   assign cpu_stall = ~reset & cpu_req & ~(cpu_we ? cpu_gnt_q : cpu_rvalid_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grants, writes and read responses;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;

   localparam int unsigned RD_LAT     = 1;
   localparam int unsigned MAX_STARVE = 3;

   logic        clockCPU;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic        cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid;
   logic [31:0] cpu_rdata, dbg_rdata;
   logic [9:0]  mem_address;
   logic [31:0] mem_data, mem_q;
   logic        mem_wren, busy, err;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   dmem_arbiter #(.RD_LAT(RD_LAT), .MAX_STARVE(MAX_STARVE), .BASE_HI(20'h10010)) dut (
      .clockCPU(clockCPU), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
      .busy(busy), .err(err)
   );

   initial begin
      clockCPU = 1'b0;
      forever #5 clockCPU = ~clockCPU;
   end

   always @(posedge clockCPU) cyc <= cyc + 1;

   // RAM model with registered read of RD_LAT cycles
   logic        ram_init;
   logic [31:0] ram [1024];
   logic [31:0] qpipe [RD_LAT];
   always @(posedge clockCPU) begin
      if (ram_init) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 32'hA500_0000 | 32'(i);
      end else if (mem_wren) begin
         ram[mem_address] <= mem_data;
      end
      qpipe[0] <= ram[mem_address];
      for (int i = 1; i < int'(RD_LAT); i++) qpipe[i] <= qpipe[i-1];
   end
   assign mem_q = qpipe[RD_LAT-1];

   typedef struct { int who; int cyc; logic err; } gnt_exp_t;
   typedef struct { logic [9:0] addr; logic [31:0] data; } wr_exp_t;
   typedef struct { logic [31:0] data; int cyc; } rd_exp_t;

   gnt_exp_t exp_gnt [$];
   wr_exp_t  exp_wr  [$];
   rd_exp_t  exp_cpu [$];
   rd_exp_t  exp_dbg [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mkaddr(input int w);
      return 32'h1001_0000 | (32'(w) << 2);
   endfunction

   // Monitor
   gnt_exp_t mg;
   wr_exp_t  mw;
   rd_exp_t  mr;
   always @(negedge clockCPU) begin
      if (!reset) begin
         if (cpu_gnt || dbg_gnt) begin
            check("gnt onehot", 32'(cpu_gnt & dbg_gnt), 32'd0);
            check("gnt expected", 32'(exp_gnt.size() != 0), 32'd1);
            if (exp_gnt.size() != 0) begin
               mg = exp_gnt.pop_front();
               check("gnt owner", 32'(dbg_gnt), 32'(mg.who));
               if (mg.cyc >= 0) check("gnt cycle", 32'(cyc), 32'(mg.cyc));
               check("err", 32'(err), 32'(mg.err));
            end
         end else if (err) begin
            check("err outside access", 32'(err), 32'd0);
         end
         if (mem_wren) begin
            check("wren in access", 32'(cpu_gnt | dbg_gnt), 32'd1);
            check("wr expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
               mw = exp_wr.pop_front();
               check("wr address", 32'(mem_address), 32'(mw.addr));
               check("wr data", mem_data, mw.data);
            end
         end
         if (cpu_rvalid) begin
            check("cpu rvalid expected", 32'(exp_cpu.size() != 0), 32'd1);
            if (exp_cpu.size() != 0) begin
               mr = exp_cpu.pop_front();
               check("cpu rdata", cpu_rdata, mr.data);
               check("cpu rvalid cycle", 32'(cyc), 32'(mr.cyc));
            end
         end
         if (dbg_rvalid) begin
            check("dbg rvalid expected", 32'(exp_dbg.size() != 0), 32'd1);
            if (exp_dbg.size() != 0) begin
               mr = exp_dbg.pop_front();
               check("dbg rdata", dbg_rdata, mr.data);
               check("dbg rvalid cycle", 32'(cyc), 32'(mr.cyc));
            end
         end
      end
   end

   // Issue one access from an idle arbiter; offsets are relative to the issue cycle (-1 = any).
   task automatic do_req(input int who, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err, input int gnt_off, input int rv_off);
      int  c0;
      bit  done;
      c0 = cyc;
      exp_gnt.push_back('{who: who, cyc: (gnt_off < 0) ? -1 : c0 + gnt_off, err: exp_err});
      if (we && !exp_err) exp_wr.push_back('{addr: addr[11:2], data: wdata});
      if (!we) begin
         if (who == 0) exp_cpu.push_back('{data: exp_rd, cyc: c0 + rv_off});
         else          exp_dbg.push_back('{data: exp_rd, cyc: c0 + rv_off});
      end
      if (who == 0) begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
         #1;
         check("cpu_stall at request", 32'(cpu_stall), 32'd1);
      end else begin
         dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      end
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clockCPU); #1;
         if (who == 0) done = we ? cpu_gnt : cpu_rvalid;
         else          done = we ? dbg_gnt : dbg_rvalid;
      end
      check("request completes", 32'(done), 32'd1);
      if (who == 0) cpu_req = 1'b0;
      else          dbg_req = 1'b0;
      @(posedge clockCPU); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int c0;
      int ncpu;
      int ndbg;
      int ngnt;
      bit ok;
      reset = 1'b1; ram_init = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      repeat (2) @(posedge clockCPU);
      #1;
      ram_init = 1'b0;
      check("reset busy", 32'(busy), 32'd0);
      check("reset gnt", 32'({cpu_gnt, dbg_gnt}), 32'd0);
      check("reset rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
      check("reset wren", 32'(mem_wren), 32'd0);
      check("reset mem_address", 32'(mem_address), 32'd0);
      check("reset mem_data", mem_data, 32'd0);
      check("reset cpu_rdata", cpu_rdata, 32'd0);
      check("reset dbg_rdata", dbg_rdata, 32'd0);
      check("reset err", 32'(err), 32'd0);
      @(posedge clockCPU); #1;
      reset = 1'b0;
      @(posedge clockCPU); #1;

      // CPU store then load of word 2
      do_req(0, 1'b1, 32'h1001_0008, 32'h1234_5678, 32'h0, 1'b0, 1, -1);
      do_req(0, 1'b0, 32'h1001_0008, 32'h0, 32'h1234_5678, 1'b0, 1, 2 + RD_LAT);

      // Debug read of word 5 while the CPU sits stalled behind it
      fork
         do_req(1, 1'b0, mkaddr(5), 32'h0, 32'hA500_0005, 1'b0, 1, 2 + RD_LAT);
         begin
            @(posedge clockCPU); #1;
            do_req(0, 1'b0, mkaddr(2), 32'h0, 32'h1234_5678, 1'b0, 3 + RD_LAT, 4 + 2 * RD_LAT);
         end
      join

      // Continuous contention of writes: grant order C C C D C C C D, one grant per 2 cycles
      c0 = cyc;
      ncpu = 0; ndbg = 0;
      for (int k = 0; k < 8; k++) begin
         if ((k % 4) == 3) begin
            exp_gnt.push_back('{who: 1, cyc: c0 + 1 + 2 * k, err: 1'b0});
            exp_wr.push_back('{addr: 10'(32 + ndbg), data: 32'hD000_0000 | 32'(ndbg)});
            ndbg++;
         end else begin
            exp_gnt.push_back('{who: 0, cyc: c0 + 1 + 2 * k, err: 1'b0});
            exp_wr.push_back('{addr: 10'(16 + ncpu), data: 32'hC000_0000 | 32'(ncpu)});
            ncpu++;
         end
      end
      ncpu = 0; ndbg = 0; ngnt = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = mkaddr(16); cpu_wdata = 32'hC000_0000;
      dbg_req = 1; dbg_we = 1; dbg_addr = mkaddr(32); dbg_wdata = 32'hD000_0000;
      for (int i = 0; i < 40 && ngnt < 8; i++) begin
         @(posedge clockCPU); #1;
         if (cpu_gnt) begin
            check("stall low at cpu gnt", 32'(cpu_stall), 32'd0);
            ncpu++; ngnt++;
            cpu_addr = mkaddr(16 + ncpu); cpu_wdata = 32'hC000_0000 | 32'(ncpu);
         end
         if (dbg_gnt) begin
            check("stall high while dbg owns", 32'(cpu_stall), 32'd1);
            ndbg++; ngnt++;
            dbg_addr = mkaddr(32 + ndbg); dbg_wdata = 32'hD000_0000 | 32'(ndbg);
         end
      end
      check("contention grants", 32'(ngnt), 32'd8);
      cpu_req = 0; dbg_req = 0;
      @(posedge clockCPU); #1;
      do_req(0, 1'b0, mkaddr(18), 32'h0, 32'hC000_0002, 1'b0, 1, 2 + RD_LAT);
      do_req(1, 1'b0, mkaddr(33), 32'h0, 32'hD000_0001, 1'b0, 1, 2 + RD_LAT);

      // Reset during the WAIT state of a CPU read
      c0 = cyc;
      exp_gnt.push_back('{who: 0, cyc: c0 + 1, err: 1'b0});
      cpu_req = 1; cpu_we = 0; cpu_addr = mkaddr(3);
      @(posedge clockCPU); #1;
      @(posedge clockCPU); #1;
      check("busy in wait", 32'(busy), 32'd1);
      reset = 1'b1; cpu_req = 1'b0;
      #1;
      check("mid reset busy", 32'(busy), 32'd0);
      check("mid reset wren", 32'(mem_wren), 32'd0);
      check("mid reset mem_address", 32'(mem_address), 32'd0);
      check("mid reset cpu_rdata", cpu_rdata, 32'd0);
      check("mid reset rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
      repeat (2) @(posedge clockCPU);
      #1;
      reset = 1'b0;
      repeat (RD_LAT + 4) @(posedge clockCPU);
      #1;
      do_req(0, 1'b0, mkaddr(3), 32'h0, 32'hA500_0003, 1'b0, 1, 2 + RD_LAT);

      // Misaligned / out-of-window addresses
`ifdef DMEM_ARB_ADDR_CHECK_EN
      do_req(0, 1'b1, 32'h1001_0002, 32'hCAFE_F00D, 32'h0, 1'b1, 1, -1);
      do_req(0, 1'b0, mkaddr(0), 32'h0, 32'hA500_0000, 1'b0, 1, 2 + RD_LAT);
      do_req(0, 1'b0, 32'h2000_0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 2 + RD_LAT);
`else
      do_req(0, 1'b1, 32'h1001_0002, 32'hCAFE_F00D, 32'h0, 1'b0, 1, -1);
      do_req(0, 1'b0, mkaddr(0), 32'h0, 32'hCAFE_F00D, 1'b0, 1, 2 + RD_LAT);
`endif

      repeat (4) @(posedge clockCPU);
      #1;
      ok = (exp_gnt.size() == 0) && (exp_wr.size() == 0) &&
           (exp_cpu.size() == 0) && (exp_dbg.size() == 0);
      check("scoreboard drained", 32'(ok), 32'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
